// File: rtl/prefix_adder_bist.sv
// prefix_adder_bist: built-in self-test driver for the prefix_adder datapath.
// It generates operand vectors, drives them into the adder and checks the
// returned sum and carry against an internal golden result every cycle. It
// reports the vector count, the error count and pass/fail.
//
// Optional feature macro: PREFIX_ADDER_BIST_ERRLOG_EN
//   defined   -> the first-failure log (fail_index, fail_s, fail_cout,
//                fail_valid) is implemented.
//   undefined -> the log registers are removed and those ports read 0.
//
// Handshake: start and abort are level-sampled, one-cycle control inputs,
// not valid/ready. start is taken only in IDLE or DONE. abort is taken only
// in RUN and wins over start and over the compare on the same edge. The
// adder path is an open loop: operands are registered, and the combinational
// result comes back within one clock.
//
// Vector sequence by index:
//   0: a=0, b=0, cin=0
//   1: a=all-ones, b=0, cin=1
//   2: a=all-ones, b=all-ones, cin=1
//   3: a=0101..(MSB first), b=1010.., cin=1
//  >=4: both xorshift32 generators step once. a=xsA[WIDTH-1:0],
//       b=xsB[WIDTH-1:0], cin=xsA[31]^xsB[31]
module prefix_adder_bist #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned NUM_VECTORS = 10000,
   parameter logic [31:0] SEED_A      = 32'h1D872B41,
   parameter logic [31:0] SEED_B      = 32'h6B8B4567
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   output logic             dut_cin,
   input  logic [WIDTH-1:0] dut_s,
   input  logic             dut_cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [31:0]      vec_count,
   output logic [31:0]      err_count,
   output logic [31:0]      fail_index,
   output logic [WIDTH-1:0] fail_s,
   output logic             fail_cout,
   output logic             fail_valid,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One xorshift32 step: x ^= x<<13; x ^= x>>17; x ^= x<<5.
   function automatic logic [31:0] xs_step(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   // Alternating pattern whose MSB is 0 when read MSB first: 0101...
   function automatic logic [WIDTH-1:0] alt_pattern();
      logic [WIDTH-1:0] p;
      p = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         p[i] = (((int'(WIDTH) - 1 - i) % 2) == 1);
      end
      return p;
   endfunction

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ALT_A    = alt_pattern();
   localparam logic [31:0]      LAST_CNT = 32'(NUM_VECTORS);

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cin_q, cin_d;
   logic [WIDTH-1:0] exp_s_q, exp_s_d;
   logic             exp_cout_q, exp_cout_d;
   logic [31:0]      xs_a_q, xs_a_d;
   logic [31:0]      xs_b_q, xs_b_d;
   logic [31:0]      vec_count_q, vec_count_d;
   logic [31:0]      err_count_q, err_count_d;

`ifdef PREFIX_ADDER_BIST_ERRLOG_EN
   logic [31:0]      fail_index_q, fail_index_d;
   logic [WIDTH-1:0] fail_s_q, fail_s_d;
   logic             fail_cout_q, fail_cout_d;
   logic             fail_valid_q, fail_valid_d;
`endif

   // Candidate next vector, chosen by the index it will occupy.
   logic [31:0]      vec_idx;
   logic [31:0]      xs_a_step;
   logic [31:0]      xs_b_step;
   logic [WIDTH-1:0] vec_a;
   logic [WIDTH-1:0] vec_b;
   logic             vec_cin;
   logic             vec_prng;
   logic [WIDTH:0]   vec_sum;
   logic             mismatch;
   logic             last_vec;

   // Index of the vector to load next: 0 on a fresh start, else the one after the vector now being checked.
   always_comb begin
      vec_idx = 32'd0;
      if (state_q == ST_RUN) begin
         vec_idx = vec_count_q + 32'd1;
      end
   end

   // Build the operands and golden result for vec_idx.
   always_comb begin
      xs_a_step = xs_step(xs_a_q);
      xs_b_step = xs_step(xs_b_q);
      vec_prng  = 1'b0;
      vec_a     = '0;
      vec_b     = '0;
      vec_cin   = 1'b0;
      case (vec_idx)
         32'd0: begin
            vec_a   = '0;
            vec_b   = '0;
            vec_cin = 1'b0;
         end
         32'd1: begin
            vec_a   = ALL_ONES;
            vec_b   = '0;
            vec_cin = 1'b1;
         end
         32'd2: begin
            vec_a   = ALL_ONES;
            vec_b   = ALL_ONES;
            vec_cin = 1'b1;
         end
         32'd3: begin
            vec_a   = ALT_A;
            vec_b   = ~ALT_A;
            vec_cin = 1'b1;
         end
         default: begin
            vec_prng = 1'b1;
            vec_a    = xs_a_step[WIDTH-1:0];
            vec_b    = xs_b_step[WIDTH-1:0];
            vec_cin  = xs_a_step[31] ^ xs_b_step[31];
         end
      endcase
      vec_sum = {1'b0, vec_a} + {1'b0, vec_b} + {{WIDTH{1'b0}}, vec_cin};
   end

   // Compare the adder's returned result against the golden result for the vector on the bus.
   always_comb begin
      mismatch = (dut_s != exp_s_q) || (dut_cout != exp_cout_q);
      last_vec = ((vec_count_q + 32'd1) == LAST_CNT);
   end

   // FSM next state plus datapath next values.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      cin_d       = cin_q;
      exp_s_d     = exp_s_q;
      exp_cout_d  = exp_cout_q;
      xs_a_d      = xs_a_q;
      xs_b_d      = xs_b_q;
      vec_count_d = vec_count_q;
      err_count_d = err_count_q;
`ifdef PREFIX_ADDER_BIST_ERRLOG_EN
      fail_index_d = fail_index_q;
      fail_s_d     = fail_s_q;
      fail_cout_d  = fail_cout_q;
      fail_valid_d = fail_valid_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_RUN;
               vec_count_d = 32'd0;
               err_count_d = 32'd0;
               xs_a_d      = SEED_A;
               xs_b_d      = SEED_B;
               a_d         = vec_a;
               b_d         = vec_b;
               cin_d       = vec_cin;
               exp_s_d     = vec_sum[WIDTH-1:0];
               exp_cout_d  = vec_sum[WIDTH];
`ifdef PREFIX_ADDER_BIST_ERRLOG_EN
               fail_index_d = 32'd0;
               fail_s_d     = '0;
               fail_cout_d  = 1'b0;
               fail_valid_d = 1'b0;
`endif
            end
         end
         ST_RUN: begin
            if (abort) begin
               // Counters and operands stay frozen where the run stopped.
               state_d = ST_IDLE;
            end else begin
               vec_count_d = vec_count_q + 32'd1;
               if (mismatch) begin
                  if (err_count_q != 32'hFFFF_FFFF) begin
                     err_count_d = err_count_q + 32'd1;
                  end
`ifdef PREFIX_ADDER_BIST_ERRLOG_EN
                  if (!fail_valid_q) begin
                     fail_index_d = vec_count_q;
                     fail_s_d     = dut_s;
                     fail_cout_d  = dut_cout;
                     fail_valid_d = 1'b1;
                  end
`endif
               end
               if (last_vec) begin
                  // Operands stay on the bus so the adder output is stable in DONE.
                  state_d = ST_DONE;
               end else begin
                  a_d        = vec_a;
                  b_d        = vec_b;
                  cin_d      = vec_cin;
                  exp_s_d    = vec_sum[WIDTH-1:0];
                  exp_cout_d = vec_sum[WIDTH];
                  if (vec_prng) begin
                     xs_a_d = xs_a_step;
                     xs_b_d = xs_b_step;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         cin_q       <= 1'b0;
         exp_s_q     <= '0;
         exp_cout_q  <= 1'b0;
         xs_a_q      <= 32'd0;
         xs_b_q      <= 32'd0;
         vec_count_q <= 32'd0;
         err_count_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cin_q       <= cin_d;
         exp_s_q     <= exp_s_d;
         exp_cout_q  <= exp_cout_d;
         xs_a_q      <= xs_a_d;
         xs_b_q      <= xs_b_d;
         vec_count_q <= vec_count_d;
         err_count_q <= err_count_d;
      end
   end

`ifdef PREFIX_ADDER_BIST_ERRLOG_EN
   // First-failure log registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_index_q <= 32'd0;
         fail_s_q     <= '0;
         fail_cout_q  <= 1'b0;
         fail_valid_q <= 1'b0;
      end else begin
         fail_index_q <= fail_index_d;
         fail_s_q     <= fail_s_d;
         fail_cout_q  <= fail_cout_d;
         fail_valid_q <= fail_valid_d;
      end
   end

   assign fail_index = fail_index_q;
   assign fail_s     = fail_s_q;
   assign fail_cout  = fail_cout_q;
   assign fail_valid = fail_valid_q;
`else
   assign fail_index = 32'd0;
   assign fail_s     = '0;
   assign fail_cout  = 1'b0;
   assign fail_valid = 1'b0;
`endif

   assign dut_a     = a_q;
   assign dut_b     = b_q;
   assign dut_cin   = cin_q;
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign pass      = (state_q == ST_DONE) && (err_count_q == 32'd0);
   assign vec_count = vec_count_q;
   assign err_count = err_count_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_prefix_adder_bist.sv
// Bench for prefix_adder_bist: a behavioural adder with selectable faults
// sits on the vector interface, and a table of expected vectors is built
// from the sequence rules with plain arithmetic.
module tb_prefix_adder_bist;

   localparam int W = 16;
   localparam int N = 16;
   localparam logic [31:0] SA = 32'h1D872B41;
   localparam logic [31:0] SB = 32'h6B8B4567;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [W-1:0]  dut_a, dut_b, dut_s, fail_s;
   logic          dut_cin, dut_cout, busy, done, pass, fail_cout, fail_valid;
   logic [31:0]   vec_count, err_count, fail_index;
   logic [1:0]    dbg_state;

   int checks = 0;
   int failures = 0;
   int mode = 0; // 0 correct adder, 1 cout stuck at 0, 2 s[0] inverted

   logic [W-1:0] ref_a [N];
   logic [W-1:0] ref_b [N];
   logic         ref_c [N];

   prefix_adder_bist #(
      .WIDTH(W), .NUM_VECTORS(N), .SEED_A(SA), .SEED_B(SB)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
      .dut_s(dut_s), .dut_cout(dut_cout),
      .busy(busy), .done(done), .pass(pass),
      .vec_count(vec_count), .err_count(err_count),
      .fail_index(fail_index), .fail_s(fail_s), .fail_cout(fail_cout),
      .fail_valid(fail_valid), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Behavioural adder with optional planted faults.
   always_comb begin
      logic [W:0] t;
      t = {1'b0, dut_a} + {1'b0, dut_b} + {{W{1'b0}}, dut_cin};
      dut_s    = t[W-1:0];
      dut_cout = t[W];
      if (mode == 1) dut_cout = 1'b0;
      if (mode == 2) dut_s[0] = ~t[0];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] xs32(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   task automatic build_model();
      logic [31:0] xa, xb;
      xa = SA;
      xb = SB;
      ref_a[0] = 16'h0000; ref_b[0] = 16'h0000; ref_c[0] = 1'b0;
      ref_a[1] = 16'hFFFF; ref_b[1] = 16'h0000; ref_c[1] = 1'b1;
      ref_a[2] = 16'hFFFF; ref_b[2] = 16'hFFFF; ref_c[2] = 1'b1;
      ref_a[3] = 16'h5555; ref_b[3] = 16'hAAAA; ref_c[3] = 1'b1;
      for (int k = 4; k < N; k++) begin
         xa = xs32(xa);
         xb = xs32(xb);
         ref_a[k] = xa[W-1:0];
         ref_b[k] = xb[W-1:0];
         ref_c[k] = xa[31] ^ xb[31];
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_ops"}, {dut_a, dut_b, 31'd0, dut_cin}, 64'd0);
      check({tag, "_flags"}, {busy, done, pass, fail_valid, fail_cout}, 64'd0);
      check({tag, "_counts"}, {vec_count, err_count}, 64'd0);
      check({tag, "_log"}, {fail_index, 16'd0, fail_s}, 64'd0);
   endtask

   // Full run with a given adder model; every operand compared cycle by cycle.
   task automatic run_full(input int m, input string name);
      int exp_err, first;
      logic [W-1:0] f_s;
      logic f_c;
      exp_err = 0; first = -1; f_s = '0; f_c = 1'b0;
      for (int k = 0; k < N; k++) begin
         logic [W:0] t;
         logic [W-1:0] s;
         logic c;
         t = {1'b0, ref_a[k]} + {1'b0, ref_b[k]} + {{W{1'b0}}, ref_c[k]};
         s = t[W-1:0];
         c = t[W];
         if (m == 1) c = 1'b0;
         if (m == 2) s[0] = ~s[0];
         if (s != t[W-1:0] || c != t[W]) begin
            exp_err++;
            if (first < 0) begin
               first = k; f_s = s; f_c = c;
            end
         end
      end
      mode = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s_a%0d", name, k), 64'(dut_a), 64'(ref_a[k]));
         check($sformatf("%s_b%0d", name, k), 64'(dut_b), 64'(ref_b[k]));
         check($sformatf("%s_c%0d", name, k), 64'(dut_cin), 64'(ref_c[k]));
         check($sformatf("%s_st%0d", name, k), {busy, done, pass}, 64'b100);
         tick();
      end
      check({name, "_end_flags"}, {busy, done}, 64'b01);
      check({name, "_pass"}, 64'(pass), 64'(exp_err == 0));
      check({name, "_vec_count"}, 64'(vec_count), 64'(N));
      check({name, "_err_count"}, 64'(err_count), 64'(exp_err));
      check({name, "_held_a"}, 64'(dut_a), 64'(ref_a[N-1]));
`ifdef PREFIX_ADDER_BIST_ERRLOG_EN
      check({name, "_fail_valid"}, 64'(fail_valid), 64'(exp_err != 0));
      if (exp_err != 0) begin
         check({name, "_fail_index"}, 64'(fail_index), 64'(first));
         check({name, "_fail_s"}, 64'(fail_s), 64'(f_s));
         check({name, "_fail_cout"}, 64'(fail_cout), 64'(f_c));
      end
`else
      check({name, "_fail_log_zero"}, {fail_index, 16'd0, fail_s},  64'd0);
      check({name, "_fail_bits_zero"}, {fail_valid, fail_cout}, 64'd0);
`endif
      tick();
      check({name, "_done_hold"}, {done, 32'd0, vec_count}, {1'b1, 32'd0, 32'(N)});
   endtask

   // Start a run, check k vectors, then abort; counters must freeze at k.
   task automatic run_abort(input int k, input string name);
      mode = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < k; i++) begin
         check($sformatf("%s_a%0d", name, i), 64'(dut_a), 64'(ref_a[i]));
         if (i == 2) start = 1'b1; // ignored while running
         tick();
         start = 1'b0;
      end
      check({name, "_pre_busy"}, {busy, vec_count}, {1'b1, 32'(k)});
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check({name, "_idle"}, {busy, done, pass}, 64'd0);
      check({name, "_vec_frozen"}, 64'(vec_count), 64'(k));
      tick();
      check({name, "_still_idle"}, {busy, done, vec_count}, {2'b00, 32'(k)});
   endtask

   initial begin
      build_model();
      #1;
      check_zero_outputs("reset");
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_zero_outputs("idle_after_reset");

      run_full(0, "good");
      repeat ($urandom_range(0, 3)) tick();
      run_full(1, "stuck_cout");
      repeat ($urandom_range(0, 3)) tick();
      run_full(2, "s0_inv");
      repeat ($urandom_range(0, 3)) tick();

      // Reset in the middle of a run clears everything at once.
      mode = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      check("mid_run_a7", 64'(dut_a), 64'(ref_a[7]));
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_full(0, "rerun");

      run_abort(5, "abort5");
      run_abort($urandom_range(1, N - 2), "abort_rand");

      // start and abort on the same RUN edge: abort wins.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("run_start_abort_idle", {busy, done}, 64'd0);
      check("run_start_abort_cnt", 64'(vec_count), 64'd2);

      // start and abort together in IDLE: start wins.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("idle_start_abort_busy", {busy, done}, 64'b10);
      check("idle_start_abort_vec0", {dut_a, dut_b, vec_count}, 64'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("final_idle", {busy, done}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
